// File: rtl/reduce_sweep_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : reduce_sweep_checker_if
// Description : Control, stimulus and result bundle between a sweep checker
//               and the reduction gate it exercises.
// Revision    : 1.0 - initial release
// ============================================================================
interface reduce_sweep_checker_if #(
    parameter int N = 3
);
    logic         start;
    logic         stop;
    logic         loop;
    logic [1:0]   op_sel;
    logic [N-1:0] stim;
    logic         dut_res;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_cnt;
    logic [N-1:0] first_err;
    logic         err_seen;

    modport master (
        output start, stop, loop, op_sel, dut_res,
        input  stim, busy, done, pass, err_cnt, first_err, err_seen
    );

    modport slave (
        input  start, stop, loop, op_sel, dut_res,
        output stim, busy, done, pass, err_cnt, first_err, err_seen
    );
endinterface
`default_nettype wire

// File: rtl/reduce_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : reduce_sweep_checker
// Description : Exhaustive sweep of 0..2^N-1 onto an N-input reduction gate,
//               comparing its output against AND/OR/XOR/NAND and reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_sweep_checker #(
    parameter int N    = 3,
    parameter int HOLD = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    reduce_sweep_checker_if.slave bus
);

    localparam int              c_HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD - 1);
    localparam logic [N-1:0]    c_STIM_LAST = {N{1'b1}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [1:0] c_OP_AND  = 2'd0;
    localparam logic [1:0] c_OP_OR   = 2'd1;
    localparam logic [1:0] c_OP_XOR  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [1:0]      r_op;
    logic [c_HW-1:0] r_hold;
    logic [N-1:0]    r_stim;
    logic [N:0]      r_err_cnt;
    logic [N-1:0]    r_first_err;
    logic            r_err_seen;
    logic            r_pass;
    logic            w_exp;
    logic            w_sample;
    logic            w_last;
    logic            w_mismatch;

    always_comb begin
        case (r_op)
            c_OP_AND: w_exp = &r_stim;
            c_OP_OR:  w_exp = |r_stim;
            c_OP_XOR: w_exp = ^r_stim;
            default:  w_exp = ~(&r_stim);
        endcase
    end

    // The gate output is sampled on the same edge that advances the pattern.
    assign w_sample   = (r_state == S_RUN) && (r_hold == c_HOLD_LAST);
    assign w_last     = (r_stim == c_STIM_LAST);
    assign w_mismatch = (bus.dut_res != w_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.stop)                w_state_nxt = S_IDLE;
                else if (w_sample && w_last) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                if (bus.stop)      w_state_nxt = S_IDLE;
                else if (bus.loop) w_state_nxt = S_RUN;
                else               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= c_OP_AND;
            r_hold      <= '0;
            r_stim      <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_err_seen  <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op        <= bus.op_sel;
                        r_hold      <= '0;
                        r_stim      <= '0;
                        r_err_cnt   <= '0;
                        r_first_err <= '0;
                        r_err_seen  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        r_stim <= '0;
                        r_hold <= '0;
                    end else if (w_sample) begin
                        if (w_mismatch) begin
                            r_err_cnt <= r_err_cnt + (N+1)'(1);
                            if (!r_err_seen) begin
                                r_first_err <= r_stim;
                                r_err_seen  <= 1'b1;
                            end
                        end
                        r_hold <= '0;
                        if (!w_last) r_stim <= r_stim + N'(1);
                    end else begin
                        r_hold <= r_hold + c_HW'(1);
                    end
                end
                S_FIN: begin
                    r_stim <= '0;
                    r_hold <= '0;
                    if (!bus.stop) begin
                        r_pass <= (r_err_cnt == '0);
                        if (bus.loop) begin
                            r_err_cnt   <= '0;
                            r_first_err <= '0;
                            r_err_seen  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_stim <= '0;
                    r_hold <= '0;
                end
            endcase
        end
    end

    // An abort during FIN suppresses the completion pulse.
    assign bus.done      = (r_state == S_FIN) && !bus.stop;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.stim      = r_stim;
    assign bus.pass      = r_pass;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.first_err = r_first_err;
    assign bus.err_seen  = r_err_seen;

endmodule
`default_nettype wire

// File: doc/reduce_sweep_checker.md
# reduce_sweep_checker

- Self-checking exhaustive stimulus engine for N-input reduction gates.
- Sweeps every input pattern 0..2^N-1 onto a DUT and holds each pattern for a set number of cycles.
- Samples the DUT output and compares it against the selected reduction (AND/OR/XOR/NAND), then reports the error count, the first failing pattern and pass/fail.
- Sits beside the gate blocks as the clocked, parametrised successor to fixed-delay free-running gate benches; usable in simulation and on-board with LEDs on `pass`/`done`.

## Interface
Parameters:
- `N`, 3, DUT input width (1..16)
- `HOLD`, 20, cycles each pattern is held (>=1)

Ports:
- `clk`  in  1  clock, rising-edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a sweep (sampled in IDLE only)
- `stop`  in  1  abort the sweep or loop
- `loop`  in  1  1 = restart the sweep automatically after the last pattern (sampled each sweep end)
- `op_sel`  in  2  expected function: 0 AND, 1 OR, 2 XOR, 3 NAND; latched at start
- `stim`  out  N  pattern driven to the DUT
- `dut_res`  in  1  DUT output (combinational from `stim`)
- `busy`  out  1  high while a sweep is running
- `done`  out  1  1-cycle pulse at the end of each completed sweep
- `pass`  out  1  result of the last completed sweep, 1 = zero errors
- `err_cnt`  out  N+1  mismatches in the current or last sweep (saturates never; max 2^N fits)
- `first_err`  out  N  pattern of the first mismatch in the current or last sweep; 0 if none
- `err_seen`  out  1  at least one mismatch in the current or last sweep

## Operation
- Reset: the following outputs are 0: `stim`, `busy`, `done`, `pass`, `err_cnt`, `first_err`, `err_seen`. FSM goes to IDLE, hold counter to 0, latched op to AND.
- FSM states: IDLE, RUN, FIN.
- IDLE: when `start`=1 → RUN; latch `op_sel`; `stim`=0, `hold_cnt`=0, `err_cnt`=0, `first_err`=0, `err_seen`=0, `busy`=1.
- RUN, per pattern:
  - `hold_cnt` counts 0..HOLD-1.
  - On the edge ending cycle `hold_cnt`==HOLD-1, compare `dut_res` with expected = reduce(op, `stim`).
  - On mismatch: `err_cnt`+1; if `err_seen`=0, capture `first_err`=`stim` and set `err_seen`.
  - Then `stim`+1, `hold_cnt`=0.
- Last pattern (`stim`=2^N-1) sampled → FIN; `stim` holds at 2^N-1.
- FIN (one cycle): `done`=1; `pass`=(final `err_cnt`==0), including a mismatch on the last pattern.
  - `loop`=1: → RUN with `stim`=0, error state cleared, `op` kept.
  - `loop`=0: → IDLE, `busy`=0.
- `stop`=1 in RUN or FIN: next state IDLE; `busy`=0, `stim`=0; no `done` pulse; `pass`/`err_cnt`/`first_err` keep their values.
  - `stop` has priority over FIN's `done`.
- `start` outside IDLE is ignored. `op_sel` changes during a sweep are ignored.
- `rst` has priority over everything, in any state, mid-sweep included.

## Timing
- `start` is seen at edge 0; `stim`=0 and `busy`=1 from edge 1.
- Each pattern is on `stim` for exactly HOLD cycles. A sweep occupies 2^N·HOLD cycles in RUN.
- `done` is high in the cycle after the last sample: edge 1+2^N·HOLD (non-loop, no stop).
- Loop mode: `done` pulses repeat every 2^N·HOLD+1 cycles; `stim`=0 is driven the cycle after FIN.
- `dut_res` is sampled on the same edge that advances `stim`, so DUT combinational delay must be < 1 clock.
- HOLD=1: a new pattern every cycle; the compare still uses the pattern currently driven.
- `err_cnt`/`first_err` update one cycle after the sampling edge is reached (registered); `pass` updates only at FIN.

## Test plan
- N=3, HOLD=4, op AND, DUT = correct AND model, `start` at cycle 0:
  - `stim` steps 0..7 every 4 cycles.
  - `done` at cycle 33; `pass`=1, `err_cnt`=0, `err_seen`=0.
- Same setup, DUT output inverted only for pattern 5 → `err_cnt`=1, `first_err`=5, `pass`=0, `done` at cycle 33.
- op_sel=OR against an AND DUT → mismatches at patterns 1..6: `err_cnt`=6, `first_err`=1, `pass`=0.
- `loop`=1, correct DUT, HOLD=2 → `done` pulses at cycles 17, 34, 51; `err_cnt` returns to 0 at each restart; `busy` stays 1 throughout.
- `stop` pulse at cycle 10 of an N=3, HOLD=4 sweep → IDLE at cycle 11, `stim`=0, `busy`=0, no `done`. `start` at cycle 15 → a full sweep runs, `done` at cycle 48.
- `rst` at cycle 12 mid-sweep → all outputs 0 on the next cycle.
  - Independently, `start` pulses while `busy`=1 → ignored, with sweep timing unchanged.
  - N=1, HOLD=1, op NAND, correct DUT → `done` at cycle 3, `pass`=1.
